fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of decode in the pipelined RISC-V core.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake with variable latency.
- Buffers returned words in a 2-entry prefetch queue and presents the head entry to decode as instrD/pcD/pcplusfourD.
- Handles decode back-pressure and execute-stage redirects (taken branch/jump).

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: execute redirect, decode hand-off and instruction-memory req/ack.
// master = fetch_stage, slave = the surrounding pipeline/memory.
interface fetch_stage_if;
  logic        pcsrcE;
  logic [31:0] pctargetE;
  logic        stallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplusfourD;

  modport master (
    input  pcsrcE, pctargetE, stallD, imem_ack, imem_rdata,
    output imem_req, imem_addr, validD, instrD, pcD, pcplusfourD
  );

  modport slave (
    output pcsrcE, pctargetE, stallD, imem_ack, imem_rdata,
    input  imem_req, imem_addr, validD, instrD, pcD, pcplusfourD
  );
endinterface

// File: rtl/fetch_stage.sv
// Owns the PC, fetches words over imem req/ack into a 2-entry queue; ack-to-validD 1 cycle.
// stallD holds the head and a full queue stops issue; FETCH_PERF_EN adds fetch/drop counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FETCH_PERF_EN
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_dropped,
`endif
  fetch_stage_if.master bus
);

  localparam logic [0:0]  IDLE  = 1'b0;
  localparam logic [0:0]  REQ   = 1'b1;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [0:0]  state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic        discard, discard_n;
  entry_t      q [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_n;
  logic        valid, ack_acc, drop_ack, push, pop;
  entry_t      head;

  assign valid    = (count != 2'd0);
  assign head     = q[rd_ptr];
  assign ack_acc  = (state == REQ) && bus.imem_ack;
  // a response is dropped if it answers a pre-redirect request or races a redirect
  assign drop_ack = ack_acc && (discard || bus.pcsrcE);
  assign push     = ack_acc && !drop_ack;
  assign pop      = valid && !bus.stallD && !bus.pcsrcE;

  always_comb begin
    count_n = count;
    if (bus.pcsrcE)
      count_n = 2'd0;
    else if (push && !pop)
      count_n = count + 2'd1;
    else if (pop && !push)
      count_n = count - 2'd1;
  end

  always_comb begin
    fetch_pc_n = fetch_pc;
    if (bus.pcsrcE)
      fetch_pc_n = bus.pctargetE & ALIGN;
    else if (push)
      fetch_pc_n = fetch_pc + 32'd4;
  end

  always_comb begin
    state_n    = state;
    req_addr_n = req_addr;
    discard_n  = discard;
    if (state == REQ && !bus.imem_ack) begin
      if (bus.pcsrcE)
        discard_n = 1'b1;
    end else begin
      discard_n = 1'b0;
      // only one request in flight, so issuing needs a queue slot beyond those already held
      if (!bus.pcsrcE && ((state == IDLE) ? (count < 2'd2) : (count_n < 2'd2))) begin
        state_n    = REQ;
        req_addr_n = fetch_pc_n;
      end else begin
        state_n    = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC & ALIGN;
      req_addr <= RESET_PC & ALIGN;
      discard  <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
      discard  <= discard_n;
      count    <= count_n;
      if (bus.pcsrcE) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= ~wr_ptr;
        if (pop)
          rd_ptr <= ~rd_ptr;
      end
    end
  end

  // payload needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (push)
      q[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_rdata};
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = req_addr;
  assign bus.validD      = valid;
  assign bus.instrD      = valid ? head.instr : NOP_INSTR;
  assign bus.pcD         = valid ? head.pc : 32'd0;
  assign bus.pcplusfourD = valid ? (head.pc + 32'd4) : 32'd0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_dropped <= 32'd0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 32'd1;
      perf_dropped <= perf_dropped + {30'd0, (bus.pcsrcE ? count : 2'd0)} + {31'd0, drop_ack};
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table, hand-written redirect/wrap/reset sequences,
// then random stall/redirect/latency traffic checked against a program-order model.
module tb_fetch_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if fif ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped),
`endif
    .bus          (fif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 0;
  int cur_lat = 0;
  int age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder: ack after cur_lat cycles of a held request, data = addr ^ K
  task automatic mem_drive();
    if (!fif.imem_req) begin
      age = 0;
      fif.imem_ack = 1'b0;
    end else begin
      if (fif.imem_ack) age = 0;
      if (age == 0) cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      fif.imem_ack   = (age >= cur_lat);
      fif.imem_rdata = fif.imem_ack ? (fif.imem_addr ^ K) : $urandom;
      age++;
    end
  endtask

  task automatic step();
    mem_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fif.pcsrcE = 1'b0; fif.pctargetE = 32'd0; fif.stallD = 1'b0;
    fif.imem_ack = 1'b0; fif.imem_rdata = 32'd0;
    age = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fif.imem_req && fif.imem_addr == addr) begin seen = 1'b1; break; end
      step();
    end
    chk({name, " req seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic first_valid(input string name, input logic [31:0] pc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fif.validD) begin seen = 1'b1; break; end
      step();
    end
    chk({name, " valid seen"}, {31'd0, seen}, 32'd1);
    chk({name, " pcD"}, fif.pcD, pc);
    chk({name, " instrD"}, fif.instrD, pc ^ K);
    chk({name, " pcplusfourD"}, fif.pcplusfourD, pc + 32'd4);
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [12];
    logic [31:0] exp_pc, p_addr, p_pc, p_instr;
    logic        p_valid, p_stall, p_redir, p_req, rd, st;
    int          consumed;

    // ack-every-cycle start-up, then a 5-cycle stall that fills the queue
    tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    tbl[4]  = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h4};
    tbl[5]  = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h4};
    tbl[6]  = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h4};
    tbl[7]  = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h4};
    tbl[8]  = '{1'b0, 1'b0, 32'h8,  1'b1, 32'h4};
    tbl[9]  = '{1'b0, 1'b0, 32'h8,  1'b1, 32'h8};
    tbl[10] = '{1'b0, 1'b1, 32'hC,  1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC};

    do_reset();
    mem_lat = 0;
`ifdef FETCH_PERF_EN
    chk("reset perf_fetched", perf_fetched, 32'd0);
    chk("reset perf_dropped", perf_dropped, 32'd0);
`endif
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t%0d imem_req", k), {31'd0, fif.imem_req}, {31'd0, tbl[k].req});
      chk($sformatf("t%0d imem_addr", k), fif.imem_addr, tbl[k].addr);
      chk($sformatf("t%0d validD", k), {31'd0, fif.validD}, {31'd0, tbl[k].valid});
      chk($sformatf("t%0d pcD", k), fif.pcD, tbl[k].valid ? tbl[k].pc : 32'd0);
      chk($sformatf("t%0d instrD", k), fif.instrD, tbl[k].valid ? (tbl[k].pc ^ K) : NOP);
      chk($sformatf("t%0d pcplusfourD", k), fif.pcplusfourD,
          tbl[k].valid ? (tbl[k].pc + 32'd4) : 32'd0);
      fif.stallD = tbl[k].stall;
      step();
    end

    // redirect while the 0x10 request waits three cycles for its ack
    do_reset();
    mem_lat = 0;
    wait_req("redir", 32'h10);
    mem_lat = 3;
    step();
    fif.pcsrcE = 1'b1; fif.pctargetE = 32'h0000_0103;
    mem_lat = 0;
    step();
    fif.pcsrcE = 1'b0;
    chk("redir flush validD", {31'd0, fif.validD}, 32'd0);
    chk("redir held req", {31'd0, fif.imem_req}, 32'd1);
    chk("redir held addr", fif.imem_addr, 32'h10);
    step();
    chk("redir wait validD", {31'd0, fif.validD}, 32'd0);
    step();
    chk("redir new req", {31'd0, fif.imem_req}, 32'd1);
    chk("redir new addr", fif.imem_addr, 32'h100);
    chk("redir drop validD", {31'd0, fif.validD}, 32'd0);
    first_valid("redir", 32'h100);

    // redirect coinciding with an ack
    do_reset();
    mem_lat = 0;
    wait_req("race", 32'h8);
    fif.pcsrcE = 1'b1; fif.pctargetE = 32'h0000_0200;
    step();
    fif.pcsrcE = 1'b0;
    chk("race flush validD", {31'd0, fif.validD}, 32'd0);
    chk("race idle req", {31'd0, fif.imem_req}, 32'd0);
    step();
    chk("race new addr", fif.imem_addr, 32'h200);
    first_valid("race", 32'h200);

    // address wrap at the top of memory (unaligned target is word-aligned)
    do_reset();
    mem_lat = 0;
    step();
    fif.pcsrcE = 1'b1; fif.pctargetE = 32'hFFFF_FFFF;
    step();
    fif.pcsrcE = 1'b0;
    chk("wrap flush validD", {31'd0, fif.validD}, 32'd0);
    step();
    chk("wrap top addr", fif.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap next req", {31'd0, fif.imem_req}, 32'd1);
    chk("wrap next addr", fif.imem_addr, 32'h0);
    chk("wrap pcD", fif.pcD, 32'hFFFF_FFFC);
    chk("wrap instrD", fif.instrD, 32'h5A5A_FFFC);
    chk("wrap pcplusfourD", fif.pcplusfourD, 32'h0);

    // asynchronous reset mid-request with one entry queued
    do_reset();
    fif.stallD = 1'b1;
    mem_lat = 0;
    step();
    step();
    mem_lat = 5;
    mem_drive();
    chk("arst pre validD", {31'd0, fif.validD}, 32'd1);
    chk("arst pre req", {31'd0, fif.imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst validD", {31'd0, fif.validD}, 32'd0);
    chk("arst imem_req", {31'd0, fif.imem_req}, 32'd0);
    chk("arst imem_addr", fif.imem_addr, 32'h0);
    chk("arst instrD", fif.instrD, NOP);
    chk("arst pcD", fif.pcD, 32'd0);
    chk("arst pcplusfourD", fif.pcplusfourD, 32'd0);
`ifdef FETCH_PERF_EN
    chk("arst perf_fetched", perf_fetched, 32'd0);
    chk("arst perf_dropped", perf_dropped, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0; fif.imem_ack = 1'b0; age = 0; fif.stallD = 1'b0; mem_lat = 0;
    st = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fif.imem_req) begin st = 1'b1; break; end
      step();
    end
    chk("arst req seen", {31'd0, st}, 32'd1);
    chk("arst first addr", fif.imem_addr, 32'h0);
    first_valid("arst", 32'h0);

    // random traffic against program order: pc runs +4 and restarts at each redirect target
    do_reset();
    mem_lat = -1;
    exp_pc = 32'h0;
    consumed = 0;
    p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0; p_req = 1'b0;
    p_addr = 32'h0; p_pc = 32'h0; p_instr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (p_valid && p_stall && !p_redir) begin
        chk("rnd hold pcD", fif.pcD, p_pc);
        chk("rnd hold instrD", fif.instrD, p_instr);
      end
      if (p_redir)
        chk("rnd flush validD", {31'd0, fif.validD}, 32'd0);
      if (p_req && !fif.imem_ack) begin
        chk("rnd req held", {31'd0, fif.imem_req}, 32'd1);
        chk("rnd addr held", fif.imem_addr, p_addr);
      end
      chk("rnd addr aligned", fif.imem_addr & 32'h3, 32'd0);
      if (!fif.validD)
        chk("rnd idle instrD", fif.instrD, NOP);

      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 3);
      fif.stallD = st;
      fif.pcsrcE = rd;
      fif.pctargetE = $urandom;
      if (rd) begin
        exp_pc = fif.pctargetE & 32'hFFFF_FFFC;
      end else if (fif.validD && !st) begin
        chk("rnd pcD", fif.pcD, exp_pc);
        chk("rnd instrD", fif.instrD, exp_pc ^ K);
        chk("rnd pcplusfourD", fif.pcplusfourD, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      p_valid = fif.validD; p_stall = st; p_redir = rd; p_req = fif.imem_req;
      p_addr = fif.imem_addr; p_pc = fif.pcD; p_instr = fif.instrD;
      step();
    end
    fif.pcsrcE = 1'b0;
    chk("rnd progress", {31'd0, (consumed > 300)}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("rnd perf_fetched covers consumed", {31'd0, (perf_fetched >= 32'(consumed))}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
